// File: rtl/sync_aligner.sv
// Pixel re-alignment stage: queues camera pixels, issues homography queries, and pairs each
// in-order return with its pending pixel while tracking coordinate mismatches.
module sync_aligner #(
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 10,
    parameter int unsigned RW    = 5,
    parameter int unsigned GW    = 6,
    parameter int unsigned BW    = 5,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNTW  = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic          clk_25,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    input  logic [7:0]    in_r,
    input  logic [7:0]    in_g,
    input  logic [7:0]    in_b,
    output logic          query_valid,
    output logic [XW-1:0] query_x,
    output logic [YW-1:0] query_y,
    input  logic          ret_valid,
    input  logic [XW-1:0] ret_x,
    input  logic [YW-1:0] ret_y,
    input  logic [RW-1:0] ret_r,
    input  logic [GW-1:0] ret_g,
    input  logic [BW-1:0] ret_b,
    input  logic          flush,
    input  logic          clr_err,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic [RW-1:0] dvi_r,
    output logic [GW-1:0] dvi_g,
    output logic [BW-1:0] dvi_b,
    output logic [RW-1:0] ccd_r,
    output logic [GW-1:0] ccd_g,
    output logic [BW-1:0] ccd_b,
    output logic          out_mis,
    output logic          mismatch,
    output logic [CNTW-1:0] mis_cnt,
    output logic          underflow,
    output logic [LW-1:0] level
);

    logic [XW-1:0] mem_x [DEPTH];
    logic [YW-1:0] mem_y [DEPTH];
    logic [RW-1:0] mem_r [DEPTH];
    logic [GW-1:0] mem_g [DEPTH];
    logic [BW-1:0] mem_b [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic          full, empty, push, pop, pop_req, mis_evt, uf_evt;
    logic [XW-1:0] ent_x;
    logic [YW-1:0] ent_y;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign in_ready = ~full & ~flush;
    assign push     = in_valid & in_ready;
    // A pop only sees entries present before this edge; a same-cycle push is not forwarded.
    assign pop_req  = ret_valid & ~flush;
    assign pop      = pop_req & ~empty;
    assign uf_evt   = pop_req & empty;
    assign ent_x    = mem_x[rd_ptr_q];
    assign ent_y    = mem_y[rd_ptr_q];
    assign mis_evt  = pop & ((ret_x != ent_x) | (ret_y != ent_y));
    assign level    = level_q;

    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_25) begin
        if (push) begin
            mem_x[wr_ptr_q] <= in_x;
            mem_y[wr_ptr_q] <= in_y;
            mem_r[wr_ptr_q] <= in_r[7 -: RW];
            mem_g[wr_ptr_q] <= in_g[7 -: GW];
            mem_b[wr_ptr_q] <= in_b[7 -: BW];
        end
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            query_valid <= 1'b0;
            query_x     <= '0;
            query_y     <= '0;
            out_valid   <= 1'b0;
            out_x       <= '0;
            out_y       <= '0;
            dvi_r       <= '0;
            dvi_g       <= '0;
            dvi_b       <= '0;
            ccd_r       <= '0;
            ccd_g       <= '0;
            ccd_b       <= '0;
            out_mis     <= 1'b0;
            mismatch    <= 1'b0;
            mis_cnt     <= '0;
            underflow   <= 1'b0;
        end else begin
            level_q     <= level_d;
            query_valid <= push;
            out_valid   <= pop;
            out_mis     <= mis_evt;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push) begin
                query_x <= in_x;
                query_y <= in_y;
            end
            if (pop) begin
                out_x <= ent_x;
                out_y <= ent_y;
                dvi_r <= mem_r[rd_ptr_q];
                dvi_g <= mem_g[rd_ptr_q];
                dvi_b <= mem_b[rd_ptr_q];
                ccd_r <= ret_r;
                ccd_g <= ret_g;
                ccd_b <= ret_b;
            end
            // Error events take precedence over a same-cycle clear.
            if (mis_evt) begin
                mismatch <= 1'b1;
                if (clr_err)       mis_cnt <= CNTW'(1);
                else if (~&mis_cnt) mis_cnt <= mis_cnt + 1'b1;
            end else if (clr_err) begin
                mismatch <= 1'b0;
                mis_cnt  <= '0;
            end
            if (uf_evt)       underflow <= 1'b1;
            else if (clr_err) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_aligner.sv
// Scoreboard bench for sync_aligner: directed vectors, expected beats queued at issue time
// and checked by an independent monitor; a second instance with CNTW=2 checks saturation.
module tb_sync_aligner;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic       clk_25 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       in_valid = 1'b0, ret_valid = 1'b0, flush = 1'b0, clr_err = 1'b0;
    logic [9:0] in_x = '0, in_y = '0, ret_x = '0, ret_y = '0;
    logic [7:0] in_r = '0, in_g = '0, in_b = '0;
    logic [4:0] ret_r = '0, ret_b = '0;
    logic [5:0] ret_g = '0;

    logic       in_ready, query_valid, out_valid, out_mis, mismatch, underflow;
    logic [9:0] query_x, query_y, out_x, out_y;
    logic [4:0] dvi_r, dvi_b, ccd_r, ccd_b;
    logic [5:0] dvi_g, ccd_g;
    logic [7:0] mis_cnt;
    logic [3:0] level;

    logic       s_in_ready, s_query_valid, s_out_valid, s_out_mis, s_mismatch, s_underflow;
    logic [9:0] s_query_x, s_query_y, s_out_x, s_out_y;
    logic [4:0] s_dvi_r, s_dvi_b, s_ccd_r, s_ccd_b;
    logic [5:0] s_dvi_g, s_ccd_g;
    logic [1:0] s_mis_cnt;
    logic [3:0] s_level;

    int checks = 0;
    int errors = 0;

    pix_t        pend[$];
    logic [19:0] exp_q[$];
    logic [52:0] exp_out[$];

    always #20 clk_25 = ~clk_25;

    sync_aligner u_dut (
        .clk_25(clk_25), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
        .ret_valid(ret_valid), .ret_x(ret_x), .ret_y(ret_y),
        .ret_r(ret_r), .ret_g(ret_g), .ret_b(ret_b), .flush(flush), .clr_err(clr_err),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
        .dvi_r(dvi_r), .dvi_g(dvi_g), .dvi_b(dvi_b),
        .ccd_r(ccd_r), .ccd_g(ccd_g), .ccd_b(ccd_b), .out_mis(out_mis),
        .mismatch(mismatch), .mis_cnt(mis_cnt), .underflow(underflow), .level(level)
    );

    sync_aligner #(.CNTW(2)) u_sat (
        .clk_25(clk_25), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_x(in_x), .in_y(in_y), .in_r(in_r), .in_g(in_g), .in_b(in_b),
        .query_valid(s_query_valid), .query_x(s_query_x), .query_y(s_query_y),
        .ret_valid(ret_valid), .ret_x(ret_x), .ret_y(ret_y),
        .ret_r(ret_r), .ret_g(ret_g), .ret_b(ret_b), .flush(flush), .clr_err(clr_err),
        .out_valid(s_out_valid), .out_x(s_out_x), .out_y(s_out_y),
        .dvi_r(s_dvi_r), .dvi_g(s_dvi_g), .dvi_b(s_dvi_b),
        .ccd_r(s_ccd_r), .ccd_g(s_ccd_g), .ccd_b(s_ccd_b), .out_mis(s_out_mis),
        .mismatch(s_mismatch), .mis_cnt(s_mis_cnt), .underflow(s_underflow), .level(s_level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_25) begin
        if (rst_n) begin
            if (query_valid) begin
                if (exp_q.size() == 0) chk("unexpected_query", 64'({query_x, query_y}), 64'hDEAD);
                else chk("query_data", 64'({query_x, query_y}), 64'(exp_q.pop_front()));
            end
            if (out_valid) begin
                if (exp_out.size() == 0) chk("unexpected_out", 64'(out_x), 64'hDEAD);
                else chk("out_beat", 64'({out_x, out_y, dvi_r, dvi_g, dvi_b,
                                          ccd_r, ccd_g, ccd_b, out_mis}),
                         64'(exp_out.pop_front()));
            end
        end
    end

    // Called at posedge+1; returns at the following posedge+1 with inputs idle.
    task automatic step(input logic pv, input logic [9:0] px, input logic [9:0] py,
                        input logic [23:0] prgb, input logic rv, input logic [9:0] rx,
                        input logic [9:0] ry, input logic [15:0] crgb, input logic fl,
                        input logic ce);
        logic take, popd, ready;
        pix_t p, e;
        ready = !fl && (pend.size() < 8);
        take  = pv && ready;
        popd  = rv && !fl && (pend.size() != 0);
        p = '{x: px, y: py, r: prgb[23:16], g: prgb[15:8], b: prgb[7:0]};
        if (fl) begin
            pend.delete();
        end else begin
            if (popd) begin
                e = pend.pop_front();
                exp_out.push_back({e.x, e.y, e.r[7:3], e.g[7:2], e.b[7:3], crgb,
                                   (rx != e.x) || (ry != e.y)});
            end
            if (take) begin
                pend.push_back(p);
                exp_q.push_back({px, py});
            end
        end
        in_valid = pv; in_x = px; in_y = py;
        {in_r, in_g, in_b} = prgb;
        ret_valid = rv; ret_x = rx; ret_y = ry;
        {ret_r, ret_g, ret_b} = crgb;
        flush = fl; clr_err = ce;
        #1;
        chk("in_ready", 64'(in_ready), 64'(ready));
        @(posedge clk_25); #1;
        chk("query_valid_timing", 64'(query_valid), 64'(take));
        chk("out_valid_timing", 64'(out_valid), 64'(popd));
        in_valid = 0; ret_valid = 0; flush = 0; clr_err = 0;
    endtask

    task automatic push_px(input logic [9:0] x, input logic [9:0] y, input logic [23:0] rgb);
        step(1'b1, x, y, rgb, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic ret_ok(input logic [15:0] ccd);
        logic [9:0] rx, ry;
        rx = (pend.size() != 0) ? pend[0].x : 10'd0;
        ry = (pend.size() != 0) ? pend[0].y : 10'd0;
        step(1'b0, '0, '0, '0, 1'b1, rx, ry, ccd, 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valids"}, 64'({query_valid, out_valid, out_mis}), 64'd0);
        chk({tag, "_data"}, 64'({query_x, query_y, out_x, out_y, dvi_r, dvi_g, dvi_b}), 64'd0);
        chk({tag, "_ccd"}, 64'({ccd_r, ccd_g, ccd_b}), 64'd0);
        chk({tag, "_flags"}, 64'({mismatch, mis_cnt, underflow, level}), 64'd0);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk_25);
        #1;
        chk_all_zero("reset");
        @(negedge clk_25); rst_n = 1'b1;
        @(posedge clk_25); #1;

        // Basic in-order pairing
        push_px(10'd1, 10'd2, 24'hF8_FC_F8);
        push_px(10'd3, 10'd4, 24'h12_34_56);
        push_px(10'd5, 10'd6, 24'hAB_CD_EF);
        ret_ok(16'h1234);
        ret_ok(16'hFFFF);
        ret_ok(16'h0001);
        idle();
        chk("basic_mismatch", 64'(mismatch), 64'd0);
        chk("basic_level", 64'(level), 64'd0);
        chk("query_x_hold", 64'({query_x, query_y}), 64'({10'd5, 10'd6}));
        chk("out_x_hold", 64'({out_x, out_y}), 64'({10'd5, 10'd6}));

        // Fill to full, blocked pushes, reopen after a pop
        for (int i = 0; i < 8; i++) push_px(10'(10 + i), 10'(20 + i), 24'(i * 24'h111111));
        chk("full_level", 64'(level), 64'd8);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        push_px(10'd99, 10'd99, 24'h0);
        chk("ninth_level", 64'(level), 64'd8);
        step(1'b1, 10'd98, 10'd98, 24'h0, 1'b1, 10'd10, 10'd20, 16'hAAAA, 1'b0, 1'b0);
        chk("reopen_in_ready", 64'(in_ready), 64'd1);
        chk("reopen_level", 64'(level), 64'd7);
        for (int i = 0; i < 7; i++) ret_ok(16'(i));

        // Streaming push+pop with pointer wrap
        push_px(10'd100, 10'd200, 24'h808080);
        push_px(10'd101, 10'd201, 24'h404040);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 10'(102 + i), 10'(202 + i), 24'(i * 24'h0A0B0C),
                 1'b1, pend[0].x, pend[0].y, 16'(i * 16'h0101), 1'b0, 1'b0);
            chk("stream_level", 64'(level), 64'd2);
        end
        ret_ok(16'h0);
        ret_ok(16'h0);

        // Coordinate mismatch and counter saturation
        push_px(10'd7, 10'd8, 24'h102030);
        step(1'b0, '0, '0, '0, 1'b1, 10'd7, 10'd7, 16'h5555, 1'b0, 1'b0);
        chk("mis_out_mis", 64'(out_mis), 64'd1);
        chk("mis_sticky", 64'(mismatch), 64'd1);
        chk("mis_cnt_1", 64'(mis_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin
            push_px(10'd7, 10'd8, 24'h102030);
            step(1'b0, '0, '0, '0, 1'b1, 10'd7, 10'd7, 16'h5555, 1'b0, 1'b0);
        end
        chk("mis_cnt_5", 64'(mis_cnt), 64'd5);
        chk("mis_cnt_sat", 64'(s_mis_cnt), 64'd3);
        ret_ok(16'h0);
        chk("mis_out_mis_clear", 64'(out_mis), 64'd0);

        // Underflow, same-cycle push on empty, clear
        step(1'b0, '0, '0, '0, 1'b1, 10'd1, 10'd1, 16'h1, 1'b0, 1'b0);
        chk("underflow_set", 64'(underflow), 64'd1);
        step(1'b1, 10'd40, 10'd41, 24'hFFFFFF, 1'b1, 10'd40, 10'd41, 16'h2, 1'b0, 1'b0);
        chk("uf_push_level", 64'(level), 64'd1);
        idle();
        step(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
        chk("clr_flags", 64'({underflow, mismatch, mis_cnt}), 64'd0);
        chk("clr_sat_cnt", 64'(s_mis_cnt), 64'd0);
        ret_ok(16'h7777);

        // Flush with simultaneous push and pop
        for (int i = 0; i < 5; i++) push_px(10'(300 + i), 10'(400 + i), 24'h0F0F0F);
        chk("pre_flush_level", 64'(level), 64'd5);
        step(1'b1, 10'd500, 10'd500, 24'h0, 1'b1, 10'd300, 10'd400, 16'h0, 1'b1, 1'b0);
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_underflow", 64'(underflow), 64'd0);
        idle();
        push_px(10'd600, 10'd601, 24'hC0C0C0);
        ret_ok(16'h4321);

        // Asynchronous reset mid-stream
        push_px(10'd700, 10'd701, 24'h111111);
        push_px(10'd702, 10'd703, 24'h222222);
        push_px(10'd704, 10'd705, 24'h333333);
        ret_ok(16'h2468);
        idle();
        #5 rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        pend.delete();
        @(negedge clk_25); rst_n = 1'b1;
        @(posedge clk_25); #1;
        chk("post_reset_level", 64'(level), 64'd0);
        idle();

        chk("query_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("out_queue_drained", 64'(exp_out.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
